// File: rtl/pc_unit.sv
// pc_unit -- fetch program counter with prioritised redirects and a stall buffer.
//
// Holds the current fetch PC and chooses the next one from three redirect
// classes (exception > exception return > branch/jump), a one-entry pending
// redirect buffer that remembers a redirect raised while fetch is stalled,
// and the sequential pc + INC path.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           advance enable (0 = fetch stall)
//   br_valid     branch/jump redirect request, target br_target
//   exc_valid    exception redirect request, target EXC_VEC
//   eret_valid   exception-return request, target epc
//   pc           current fetch PC (registered)
//   pc_plus      pc + INC, wraps modulo 2^WIDTH (combinational)
//   pc_valid     fetch address valid (registered)
//   redirected   one-cycle pulse after an edge that loaded a redirect
//   pend_valid   a redirect is buffered awaiting en
//   pc_misalign  pc[1:0] != 0 (combinational)

module pc_unit #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VEC = WIDTH'(32'hBFC0_0000),
    parameter logic [WIDTH-1:0]     EXC_VEC   = WIDTH'(32'hBFC0_0380),
    parameter int unsigned          INC       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pc_valid,
    output logic             redirected,
    output logic             pend_valid,
    output logic             pc_misalign
);

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_BR   = 2'd1;
    localparam logic [1:0] CLS_ERET = 2'd2;
    localparam logic [1:0] CLS_EXC  = 2'd3;

    logic [1:0]       live_cls;
    logic [WIDTH-1:0] live_tgt;
    logic             live_vld;
    logic [1:0]       pend_cls;
    logic [WIDTH-1:0] pend_tgt;
    logic             pend_capture;

    // Highest-ranked request asserted this cycle.
    always_comb begin
        live_cls = CLS_NONE;
        live_tgt = br_target;
        if (exc_valid) begin
            live_cls = CLS_EXC;
            live_tgt = EXC_VEC;
        end else if (eret_valid) begin
            live_cls = CLS_ERET;
            live_tgt = epc;
        end else if (br_valid) begin
            live_cls = CLS_BR;
            live_tgt = br_target;
        end
    end

    assign live_vld    = (live_cls != CLS_NONE);
    assign pc_plus     = pc + WIDTH'(INC);
    assign pc_misalign = |pc[1:0];

    // A stalled request replaces the buffer if the buffer is empty or the new
    // request ranks at least as high; a later equal-rank request wins.
    assign pend_capture = pc_valid && !en && live_vld &&
                          (!pend_valid || (live_cls >= pend_cls));

    // Control state and PC. The first edge after reset only raises pc_valid,
    // so RESET_VEC is the first PC seen as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_VEC;
            pc_valid   <= 1'b0;
            redirected <= 1'b0;
            pend_valid <= 1'b0;
            pend_cls   <= CLS_NONE;
        end else if (!pc_valid) begin
            pc_valid   <= 1'b1;
            redirected <= 1'b0;
        end else if (en) begin
            if (live_vld) begin
                pc <= live_tgt;
            end else if (pend_valid) begin
                pc <= pend_tgt;
            end else begin
                pc <= pc_plus;
            end
            redirected <= live_vld || pend_valid;
            pend_valid <= 1'b0;
            pend_cls   <= CLS_NONE;
        end else begin
            redirected <= 1'b0;
            if (pend_capture) begin
                pend_valid <= 1'b1;
                pend_cls   <= live_cls;
            end
        end
    end

    // Buffered target is data only; it is ignored whenever pend_valid is low.
    always_ff @(posedge clk) begin
        if (pend_capture) begin
            pend_tgt <= live_tgt;
        end
    end

endmodule
